// File: rtl/scemi_in_pipe_proxy_f_pkg.sv
// scemi_in_pipe_proxy_f_pkg: shared state encoding, bind-result layout and host-call identifiers
package scemi_in_pipe_proxy_f_pkg;
  typedef enum logic [1:0] {
    ST_BIND  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;
  // Bind result as returned by the host: valid flag in bit 32, proxy index below it.
  typedef struct packed {
    logic        valid;
    logic [31:0] index;
  } bind_res_t;
  // Host calls, one strobe each: $imported_bsvscemi_bind_inpipe, _inpipe_proxy_can_put,
  // _inpipe_proxy_data_put, _inpipe_proxy_flush, _shutdown, and the $finish(0) on a failed bind.
  typedef enum logic [2:0] {
    CALL_BIND,
    CALL_CAN_PUT,
    CALL_DATA_PUT,
    CALL_FLUSH,
    CALL_SHUTDOWN,
    CALL_FINISH
  } call_e;
  localparam int N_CALLS = 6;
endpackage

// File: rtl/scemi_in_pipe_proxy_f_if.sv
// scemi_in_pipe_proxy_f_if: transactor PUT/FLUSH handshake plus the host-call channel
interface scemi_in_pipe_proxy_f_if #(parameter int WIDTH = 8);
  import scemi_in_pipe_proxy_f_pkg::*;
  logic               PUT;
  logic [WIDTH-1:0]   PUT_DATA;
  logic               PUT_RDY;
  logic               FLUSH;
  logic               FLUSH_RDY;
  logic               FLUSH_DONE;
  logic [1:0]         COUNT;
  logic               SHUTDOWN;
  logic               SHUTDOWN_RDY;
  logic [N_CALLS-1:0] calls;
  logic [31:0]        call_index;
  logic [WIDTH-1:0]   call_data;
  bind_res_t          bind_res;
  logic               can_put_res;
  modport master (
    output PUT, PUT_DATA, FLUSH, SHUTDOWN,
    input  PUT_RDY, FLUSH_RDY, FLUSH_DONE, COUNT, SHUTDOWN_RDY
  );
  modport slave (
    input  PUT, PUT_DATA, FLUSH, SHUTDOWN, bind_res, can_put_res,
    output PUT_RDY, FLUSH_RDY, FLUSH_DONE, COUNT, SHUTDOWN_RDY, calls, call_index, call_data
  );
  modport host (
    input  calls, call_index, call_data,
    output bind_res, can_put_res
  );
endinterface

// File: rtl/scemi_in_pipe_proxy_f_fifo2.sv
// scemi_in_pipe_proxy_f_fifo2: two-entry guarded FIFO, head in slot 0
module scemi_in_pipe_proxy_f_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENQ,
  input  logic             DEQ,
  input  logic [WIDTH-1:0] D_IN,
  output logic [WIDTH-1:0] D_OUT,
  output logic             FULL_N,
  output logic             EMPTY_N
);
  logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
  logic             v0_q, v0_d, v1_q, v1_d;
  logic             enq_ok, deq_ok;

  assign FULL_N  = !v1_q;
  assign EMPTY_N = v0_q;
  assign D_OUT   = d0_q;
  assign enq_ok  = ENQ && !v1_q;
  assign deq_ok  = DEQ && v0_q;

  // Shift on dequeue first, then place the new element in the first free slot.
  always_comb begin
    d0_d = d0_q;
    d1_d = d1_q;
    v0_d = v0_q;
    v1_d = v1_q;
    if (deq_ok) begin
      d0_d = d1_q;
      v0_d = v1_q;
      v1_d = 1'b0;
    end
    if (enq_ok) begin
      if (v0_d) begin
        d1_d = D_IN;
        v1_d = 1'b1;
      end else begin
        d0_d = D_IN;
        v0_d = 1'b1;
      end
    end
  end

  // Storage and occupancy registers; reset discards contents.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      d0_q <= '0;
      d1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      d0_q <= d0_d;
      d1_q <= d1_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
    end
  end
endmodule

// File: rtl/scemi_in_pipe_proxy_f.sv
// scemi_in_pipe_proxy_f: hardware-to-host SCE-MI input-pipe proxy with flush and shutdown
module scemi_in_pipe_proxy_f
  import scemi_in_pipe_proxy_f_pkg::*;
#(
  parameter string paramFile      = "",
  parameter string transactorName = "",
  parameter string portName       = "",
  parameter int    WIDTH          = 8
) (
  input logic                    CLK,
  input logic                    RST_N,
  scemi_in_pipe_proxy_f_if.slave p
);
  if (WIDTH < 1) begin : g_width_check
    $error("%s.%s (%s): WIDTH must be at least 1", transactorName, portName, paramFile);
  end

  state_e           state_q, state_d;
  logic [31:0]      proxy_index_q, proxy_index_d;
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head;
  logic             full_n, empty_n;
  logic             put_rdy, enq, deq, poll, flush_acc, bind_call, bind_ok, flush_call;

  scemi_in_pipe_proxy_f_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .ENQ     (enq),
    .DEQ     (deq),
    .D_IN    (p.PUT_DATA),
    .D_OUT   (head),
    .FULL_N  (full_n),
    .EMPTY_N (empty_n)
  );

  // Host calls only happen out of reset; the drain polls in RUN and FLUSH alike.
  assign put_rdy    = state_q == ST_RUN && full_n;
  assign enq        = p.PUT && put_rdy;
  assign flush_acc  = p.FLUSH && state_q == ST_RUN;
  assign bind_call  = RST_N && state_q == ST_BIND;
  assign bind_ok    = bind_call && p.bind_res.valid;
  assign poll       = RST_N && state_q != ST_BIND && empty_n;
  assign deq        = poll && p.can_put_res;
  assign flush_call = RST_N && state_q == ST_FLUSH && !empty_n;

  // Handshake outputs and host-call strobes for this cycle.
  always_comb begin
    p.PUT_RDY                = put_rdy;
    p.FLUSH_RDY              = state_q == ST_RUN;
    p.FLUSH_DONE             = flush_call;
    p.COUNT                  = count_q;
    p.SHUTDOWN_RDY           = 1'b1;
    p.call_index             = proxy_index_q;
    p.call_data              = head;
    p.calls                  = '0;
    p.calls[CALL_BIND]       = bind_call;
    p.calls[CALL_CAN_PUT]    = poll;
    p.calls[CALL_DATA_PUT]   = deq;
    p.calls[CALL_FLUSH]      = flush_call;
    p.calls[CALL_SHUTDOWN]   = RST_N && p.SHUTDOWN;
    p.calls[CALL_FINISH]     = bind_call && !p.bind_res.valid;
  end

  // Next state: bind into RUN, enter FLUSH on request, leave it once the host is notified.
  always_comb begin
    state_d       = bind_ok ? ST_RUN : flush_acc ? ST_FLUSH : flush_call ? ST_RUN : state_q;
    proxy_index_d = bind_ok ? p.bind_res.index : proxy_index_q;
    count_d       = count_q + 2'(enq) - 2'(deq);
  end

  // State, bound proxy index and occupancy count.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= ST_BIND;
      proxy_index_q <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      proxy_index_q <= proxy_index_d;
      count_q       <= count_d;
    end
  end
endmodule
